// File: rtl/mont_mult_ctl.sv
// mont_mult_ctl
//   Handshaked radix-2 Montgomery multiplier: z = x * y * 2^-WIDTH mod m.
//   Operands are captured on an accepted start (start=1 while ready=1).
//   The loop runs one bit of x per cycle, then a final conditional
//   subtraction brings the result into [0, m). An even modulus ends the
//   operation after one cycle with err=1 and z=0.
//
// Ports
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset
//   start : operation request, sampled only while ready=1
//   x, y  : operands (caller keeps them below m)
//   m     : modulus, must be odd
//   ready : idle, able to accept start
//   done  : one-cycle completion pulse (result or error)
//   err   : last completed operation had an even modulus
//   z     : result register, held between operations
module mont_mult_ctl #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] m,
  output logic             ready,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] z
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOOP  = 2'd1,
    S_FINAL = 2'd2,
    S_ERR   = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] xsh_q, xsh_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] z_q, z_d;
  logic [WIDTH+1:0] s_q, s_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [WIDTH+1:0] y_ext;
  logic [WIDTH+1:0] m_ext;
  logic [WIDTH+1:0] t_add;
  logic [WIDTH+1:0] t_red;

  assign y_ext = {2'b00, y_q};
  assign m_ext = {2'b00, m_q};

  // One Montgomery step. x is consumed LSB-first from a right-shifting copy,
  // so the current bit is always xsh_q[0]. s < 2m keeps t below 4m, which
  // fits the WIDTH+2-bit accumulator.
  assign t_add = s_q + (xsh_q[0] ? y_ext : '0);
  assign t_red = t_add + (t_add[0] ? m_ext : '0);

  always_comb begin
    state_d = state_q;
    xsh_d   = xsh_q;
    y_d     = y_q;
    m_d     = m_q;
    z_d     = z_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          xsh_d   = x;
          y_d     = y;
          m_d     = m;
          s_d     = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = m[0] ? S_LOOP : S_ERR;
        end
      end
      S_LOOP: begin
        s_d   = t_red >> 1;
        xsh_d = xsh_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          state_d = S_FINAL;
        end
      end
      S_FINAL: begin
        z_d     = (s_q >= m_ext) ? WIDTH'(s_q - m_ext) : WIDTH'(s_q);
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      S_ERR: begin
        z_d     = '0;
        err_d   = 1'b1;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      xsh_q   <= '0;
      y_q     <= '0;
      m_q     <= '0;
      z_q     <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      xsh_q   <= xsh_d;
      y_q     <= y_d;
      m_q     <= m_d;
      z_q     <= z_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign ready = (state_q == S_IDLE);
  assign done  = done_q;
  assign err   = err_q;
  assign z     = z_q;

endmodule
